// File: rtl/pio_pkg.sv
// pio_pkg: register map, STATUS bit layout, write-strobe bundle and timer
// state encoding shared by pio_out_pulse and pio_pulse_timer.
package pio_pkg;

  // Avalon-MM word addresses (2 and 3 are reserved)
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd6;
  localparam logic [2:0] ADDR_PULSE     = 3'd7;

  // STATUS register layout
  localparam int STATUS_BUSY_BIT = 0;

  // One-hot write strobes, at most one set per cycle
  typedef struct packed {
    logic data;
    logic set;
    logic clr;
    logic len;
    logic pulse;
  } wr_strobe_t;

  // Pulse timer state
  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

  // Exact address decode of a bus write into per-register strobes
  function automatic wr_strobe_t decode_write(input logic       chipselect,
                                              input logic       write_n,
                                              input logic [2:0] address);
    wr_strobe_t s;
    logic       wr;
    wr      = chipselect && !write_n;
    s.data  = wr && (address == ADDR_DATA);
    s.set   = wr && (address == ADDR_OUTSET);
    s.clr   = wr && (address == ADDR_OUTCLEAR);
    s.len   = wr && (address == ADDR_PULSE_LEN);
    s.pulse = wr && (address == ADDR_PULSE);
    return s;
  endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// pio_pulse_timer: pulse length register, pulse mask, down-counter and busy
// flag. Raises o_expire in the cycle the counter runs out so the parent can
// drop the masked output bits on the same edge.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  wr_strobe_t       i_wr,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [CNT_W-1:0] i_len_wd,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_expire,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_len
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tmr_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [WIDTH-1:0] r_mask;

  logic             w_pulse_go;
  logic             w_expire;
  logic             w_cpu_touch;
  logic [CNT_W-1:0] w_load;

  // A PULSE write with no data bits is a no-op
  assign w_pulse_go  = i_wr.pulse && (i_wd != '0);
  // Counter is 1 on the last high cycle; the next edge takes it to 0
  assign w_expire    = (r_state == TMR_RUN) && (r_cnt == CNT_ONE);
  // OUTSET/OUTCLEAR hand the written bits back to software control
  assign w_cpu_touch = i_wr.set || i_wr.clr;
  // A zero length still yields a one-cycle pulse
  assign w_load      = (r_len == '0) ? CNT_ONE : r_len;

  // Pulse length register; a new length only applies to the next PULSE write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= '0;
    end else if (i_wr.len) begin
      r_len <= i_len_wd;
    end
  end

  // Timer FSM: DATA kills the pulse, PULSE (re)arms it, otherwise count down
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TMR_IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else if (i_wr.data) begin
      r_state <= TMR_IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else if (w_pulse_go) begin
      // Old mask bits are kept, so a PULSE on the expiry cycle extends them
      r_state <= TMR_RUN;
      r_cnt   <= w_load;
      r_mask  <= r_mask | i_wd;
    end else begin
      case (r_state)
        TMR_IDLE: begin
          r_cnt  <= '0;
          r_mask <= '0;
        end
        TMR_RUN: begin
          if (w_expire) begin
            r_state <= TMR_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            if (w_cpu_touch) begin
              r_mask <= r_mask & ~i_wd;
            end
          end
        end
        default: begin
          r_state <= TMR_IDLE;
          r_cnt   <= '0;
          r_mask  <= '0;
        end
      endcase
    end
  end

  assign o_mask   = r_mask;
  assign o_expire = w_expire;
  assign o_busy   = (r_state == TMR_RUN);
  assign o_len    = r_len;

endmodule

// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM parallel output port with set/clear aliases and an
// optional self-clearing pulse generator.
// Build option: define PIO_OUT_PULSE_PULSE_EN to include the pulse timer
// (STATUS busy, PULSE_LEN and PULSE registers). Without it those addresses
// read 0 and ignore writes.
module pio_out_pulse
  import pio_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  wr_strobe_t       w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_expire_clr;
  logic             w_pulse_go;
  logic             w_busy;
  logic [CNT_W-1:0] w_len;
  logic             w_unused;

  assign w_wr = decode_write(chipselect, write_n, address);
  assign w_wd = writedata[WIDTH-1:0];

`ifdef PIO_OUT_PULSE_PULSE_EN
  logic [WIDTH-1:0] w_mask;
  logic             w_expire;

  pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_wr     (w_wr),
    .i_wd     (w_wd),
    .i_len_wd (writedata[CNT_W-1:0]),
    .o_mask   (w_mask),
    .o_expire (w_expire),
    .o_busy   (w_busy),
    .o_len    (w_len)
  );

  assign w_expire_clr = w_expire ? w_mask : '0;
  assign w_pulse_go   = w_wr.pulse && (w_wd != '0);
`else
  assign w_expire_clr = '0;
  assign w_pulse_go   = 1'b0;
  assign w_busy       = 1'b0;
  assign w_len        = '0;
`endif

  // Upper write-data bits and the pulse strobes are legitimately unused in some builds
  assign w_unused = ^{writedata, w_wr};

  // Next output value: CPU writes win over an expiring pulse for the bits they touch
  always_comb begin
    w_out_next = r_out & ~w_expire_clr;
    if (w_wr.data) begin
      w_out_next = w_wd;
    end else if (w_wr.set) begin
      w_out_next = (r_out & ~w_expire_clr) | w_wd;
    end else if (w_wr.clr) begin
      w_out_next = r_out & ~w_expire_clr & ~w_wd;
    end else if (w_pulse_go) begin
      // Expiring bits are not cleared here: a new pulse carries them on
      w_out_next = r_out | w_wd;
    end
  end

  // Output register, driven straight onto the pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= RESET_VALUE[WIDTH-1:0];
    end else begin
      r_out <= w_out_next;
    end
  end

  assign out_port = r_out;

  // Zero-wait-state read mux, zero-extended; write-only and reserved read 0
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(r_out);
      ADDR_STATUS:    readdata[STATUS_BUSY_BIT] = w_busy;
      ADDR_PULSE_LEN: readdata = 32'(w_len);
      default:        readdata = '0;
    endcase
  end

endmodule
